// File: rtl/mux_deser_pkg.sv
// Shared types and width bounds for the mux output deserializer.
package mux_deser_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } deser_state_t;

  localparam int unsigned DESER_W_MIN = 2;
  localparam int unsigned DESER_W_MAX = 32;

endpackage

// File: rtl/deser_bit_counter.sv
// Modulo-W bit counter; clr has priority over inc, last flags count == W-1.
module deser_bit_counter #(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [$clog2(W)-1:0] count,
  output logic                 last
);

  localparam int unsigned   CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_VAL = CW'(W - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == LAST_VAL) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/mux_out_deserializer.sv
// Serial-to-parallel collector with a single-entry valid/ready output word.
// Only the word-completing bit stalls while the previous word is unconsumed.
module mux_out_deserializer
  import mux_deser_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 flush,
  output logic [W-1:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [$clog2(W)-1:0] bit_count
);

  if (W < DESER_W_MIN || W > DESER_W_MAX) begin : g_w_check
    $error("mux_out_deserializer: W=%0d outside legal range", W);
  end

  deser_state_t state_q;
  deser_state_t state_d;
  logic [W-2:0] sr_q;
  logic [W-2:0] sr_d;
  logic [W-1:0] dout_q;
  logic [W-1:0] dout_d;
  logic [W-1:0] word_c;
  logic         last;
  logic         acc;
  logic         complete;

  assign dout_valid = (state_q == FULL);
  assign din_ready  = !(dout_valid && !dout_ready && last);
  assign acc        = din_valid && din_ready;
  assign complete   = acc && last && !flush;

  // Shift register plus the incoming bit, in arrival order for the chosen bit order
  assign word_c = MSB_FIRST ? {sr_q, din} : {din, sr_q};

  deser_bit_counter #(
    .W(W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (acc),
    .clr  (flush),
    .count(bit_count),
    .last (last)
  );

  always_comb begin
    sr_d = sr_q;
    if (flush) begin
      sr_d = '0;
    end else if (acc) begin
      sr_d = MSB_FIRST ? word_c[W-2:0] : word_c[W-1:1];
    end
  end

  // Output FSM: a completing word always loads, even on top of a popped one
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          dout_d  = word_c;
        end
      end
      FULL: begin
        if (complete) begin
          dout_d = word_c;
        end else if (dout_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_mux_out_deserializer.sv
// Bench for mux_out_deserializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a bit-queue model, plus literal word checks.
module tb_mux_out_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din;
  logic          din_valid;
  logic          flush;
  logic          dout_ready;
  logic          din_ready0, din_ready1;
  logic [W-1:0]  dout0, dout1;
  logic          dv0, dv1;
  logic [CW-1:0] bc0, bc1;

  always #5 clk = ~clk;

  mux_out_deserializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
    .flush(flush), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready), .bit_count(bc0)
  );

  mux_out_deserializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
    .flush(flush), .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready), .bit_count(bc1)
  );

  // Reference model: queue of bits received for the partial word, one pending word
  bit           mq[$];
  bit           m_valid = 1'b0;
  bit [W-1:0]   m_dout0 = '0;
  bit [W-1:0]   m_dout1 = '0;
  int           n_acc = 0;
  int           n_pop_m = 0;

  always @(posedge clk) begin
    bit rdy, acc, pop, done;
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_dout0 = '0;
      m_dout1 = '0;
    end else begin
      rdy  = !(m_valid && !dout_ready && mq.size() == W - 1);
      acc  = din_valid && rdy;
      pop  = m_valid && dout_ready;
      done = 1'b0;
      if (acc) n_acc++;
      if (pop) n_pop_m++;
      if (flush) begin
        mq.delete();
      end else if (acc) begin
        mq.push_back(din);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++) begin
            m_dout0[W-1-i] = mq[i];
            m_dout1[i]     = mq[i];
          end
          mq.delete();
          done = 1'b1;
        end
      end
      if (done) m_valid = 1'b1;
      else if (pop) m_valid = 1'b0;
    end
  end

  int         total = 0;
  int         bad = 0;
  int         n_pop_d = 0;
  bit         chk_en = 1'b0;
  bit         p_stall0 = 1'b0, p_stall1 = 1'b0;
  logic [W-1:0] p_dout0 = '0, p_dout1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    bit exp_rdy;
    if (!chk_en) return;
    exp_rdy = !(m_valid && !dout_ready && mq.size() == W - 1);
    chk("din_ready_msb", 32'(din_ready0), 32'(exp_rdy));
    chk("din_ready_lsb", 32'(din_ready1), 32'(exp_rdy));
    chk("dout_valid_msb", 32'(dv0), 32'(m_valid));
    chk("dout_valid_lsb", 32'(dv1), 32'(m_valid));
    chk("dout_msb", 32'(dout0), 32'(m_dout0));
    chk("dout_lsb", 32'(dout1), 32'(m_dout1));
    chk("bit_count_msb", 32'(bc0), 32'(mq.size()));
    chk("bit_count_lsb", 32'(bc1), 32'(mq.size()));
    if (p_stall0) chk("stall_stable_msb", 32'(dout0), 32'(p_dout0));
    if (p_stall1) chk("stall_stable_lsb", 32'(dout1), 32'(p_dout1));
    p_stall0 = dv0 && !dout_ready && rst_n;
    p_stall1 = dv1 && !dout_ready && rst_n;
    p_dout0  = dout0;
    p_dout1  = dout1;
    if (dv0 && dout_ready && rst_n) n_pop_d++;
  endtask

  // One clock: compare mid-cycle, then return just after the next rising edge
  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    din       = b;
    din_valid = 1'b1;
    step();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send(w[W-1-i]);
  endtask

  initial begin
    int cyc;
    int start;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", 32'(dv0), 32'd0);
    chk("rst_count", 32'(bc0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_din_ready", 32'(din_ready0), 32'd1);

    // Basic word, both bit orders
    dout_ready = 1'b1;
    send_word(8'b1011_0010, 8);
    din_valid = 1'b0;
    chk("w1_msb", 32'(dout0), 32'hB2);
    chk("w1_lsb", 32'(dout1), 32'h4D);
    chk("w1_valid", 32'(dv0), 32'd1);
    step();
    chk("w1_valid_fall", 32'(dv0), 32'd0);

    // Backpressure: only the completing bit of the second word stalls
    dout_ready = 1'b0;
    send_word(8'hB2, 8);
    chk("bp_first_valid", 32'(dv0), 32'd1);
    send_word(8'h71, 7);
    chk("bp_count7", 32'(bc0), 32'd7);
    chk("bp_hold_dout", 32'(dout0), 32'hB2);
    din = 1'b1; din_valid = 1'b1; #1;
    chk("bp_stall_ready", 32'(din_ready0), 32'd0);
    step();
    chk("bp_still_count7", 32'(bc0), 32'd7);
    chk("bp_still_dout", 32'(dout0), 32'hB2);
    dout_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(din_ready0), 32'd1);
    step();
    din_valid = 1'b0;
    chk("bp_w2_valid", 32'(dv0), 32'd1);
    chk("bp_w2_msb", 32'(dout0), 32'h71);
    chk("bp_w2_lsb", 32'(dout1), 32'h8E);
    chk("bp_w2_count", 32'(bc0), 32'd0);
    step();
    chk("bp_w2_popped", 32'(dv0), 32'd0);

    // Flush with a 6th bit drops the partial word
    send_word(8'b1010_1000, 5);
    chk("fl_count5", 32'(bc0), 32'd5);
    din = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count0", 32'(bc0), 32'd0);
    chk("fl_no_word", 32'(dv0), 32'd0);
    send_word(8'hCA, 8);
    din_valid = 1'b0;
    chk("fl_clean_msb", 32'(dout0), 32'hCA);
    chk("fl_clean_lsb", 32'(dout1), 32'h53);
    step();

    // Reset mid-word while a word is pending
    dout_ready = 1'b0;
    send_word(8'hB2, 8);
    send_word(8'hF0, 4);
    din_valid = 1'b0;
    chk("mr_count4", 32'(bc0), 32'd4);
    chk("mr_valid", 32'(dv0), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_dout", 32'(dout0), 32'd0);
    chk("mr_valid0", 32'(dv0), 32'd0);
    chk("mr_count0", 32'(bc0), 32'd0);
    chk("mr_din_ready", 32'(din_ready0), 32'd1);

    // Randomized traffic
    cyc   = 0;
    start = n_acc;
    while ((n_acc - start) < 1000 && cyc < 30000) begin
      din        = 1'($urandom);
      din_valid  = ($urandom_range(0, 9) < 7);
      dout_ready = ($urandom_range(0, 9) < 5);
      flush      = ($urandom_range(0, 99) == 0);
      step();
      cyc++;
    end
    flush = 1'b0; din_valid = 1'b0;
    chk("rand_budget", 32'((n_acc - start) >= 1000), 32'd1);
    chk("pop_count", 32'(n_pop_d), 32'(n_pop_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
